// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Arbitrates one external memory bus between the fetch port and
//               the data port. Runs the active-low acknowledge handshake,
//               returns registered read data with one-cycle ack pulses, and
//               aborts a stuck transaction with a bus-error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int TIMEOUT    = 16,   // 2..255 cycles allowed on the bus
    parameter int STARVE_MAX = 4     // 1..15 data grants while fetch waits
) (
    input  logic        clk,
    input  logic        reset_x,
    // fetch port
    input  logic        Fi_req,
    input  logic [31:0] Fi_addr,
    output logic [31:0] Fo_rdata,
    output logic        Fo_ack,
    output logic        Fo_stall,
    // data port
    input  logic        Mi_req,
    input  logic        Mi_write,
    input  logic [1:0]  Mi_size,
    input  logic [31:0] Mi_addr,
    input  logic [31:0] Mi_wdata,
    output logic [31:0] Mo_rdata,
    output logic        Mo_ack,
    output logic        Mo_stall,
    output logic        Mo_busErr,
    // memory bus
    output logic [31:0] Bo_addr,
    output logic        Bo_req,
    output logic        Bo_write,
    output logic [1:0]  Bo_size,
    output logic [31:0] Bo_wdata,
    input  logic [31:0] Bi_rdata,
    input  logic        Bi_ack_n
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FBUS = 2'd1,
        DBUS = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [7:0] C_WDOG_LAST  = 8'(TIMEOUT - 1);
    localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

    state_t      state_q,   state_d;
    logic [3:0]  starve_q,  starve_d;
    logic [7:0]  wdog_q,    wdog_d;
    logic [31:0] addr_q,    addr_d;
    logic [31:0] wdata_q,   wdata_d;
    logic        write_q,   write_d;
    logic [1:0]  size_q,    size_d;
    logic        owner_q,   owner_d;    // 1 = data port owns the transaction
    logic        err_q,     err_d;
    logic [31:0] f_rdata_q, f_rdata_d;
    logic [31:0] m_rdata_q, m_rdata_d;

    // Grant decision, bus handshake, watchdog and response sequencing
    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        wdog_d    = wdog_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        size_d    = size_q;
        owner_d   = owner_q;
        err_d     = err_q;
        f_rdata_d = f_rdata_q;
        m_rdata_d = m_rdata_q;

        case (state_q)
            IDLE: begin
                if (Mi_req && ((starve_q < C_STARVE_MAX) || !Fi_req)) begin
                    state_d = DBUS;
                    owner_d = 1'b1;
                    addr_d  = Mi_addr;
                    write_d = Mi_write;
                    size_d  = Mi_size;
                    wdata_d = Mi_wdata;
                    wdog_d  = 8'd0;
                    err_d   = 1'b0;
                    // With fetch waiting this branch is only taken below
                    // STARVE_MAX, so the increment saturates by construction.
                    starve_d = Fi_req ? (starve_q + 4'd1) : 4'd0;
                end else if (Fi_req) begin
                    state_d  = FBUS;
                    owner_d  = 1'b0;
                    addr_d   = Fi_addr;
                    write_d  = 1'b0;
                    size_d   = 2'b10;
                    wdog_d   = 8'd0;
                    err_d    = 1'b0;
                    starve_d = 4'd0;
                end
            end
            FBUS, DBUS: begin
                if (!Bi_ack_n) begin
                    state_d = RESP;
                    if (owner_q) begin
                        m_rdata_d = write_q ? 32'h0 : Bi_rdata;
                    end else begin
                        f_rdata_d = Bi_rdata;
                    end
                end else if (wdog_q == C_WDOG_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    if (owner_q) begin
                        m_rdata_d = 32'h0;
                    end else begin
                        f_rdata_d = 32'h0;
                    end
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            RESP: begin
                // no grant here so a requester dropping on ack is not re-served
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_x) begin
            state_q   <= IDLE;
            starve_q  <= 4'd0;
            wdog_q    <= 8'd0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            write_q   <= 1'b0;
            size_q    <= 2'b10;
            owner_q   <= 1'b0;
            err_q     <= 1'b0;
            f_rdata_q <= 32'h0;
            m_rdata_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            wdog_q    <= wdog_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            size_q    <= size_d;
            owner_q   <= owner_d;
            err_q     <= err_d;
            f_rdata_q <= f_rdata_d;
            m_rdata_q <= m_rdata_d;
        end
    end

    // Output decode: bus registers always visible, Bo_req qualifies them
    always_comb begin
        Bo_req    = (state_q == FBUS) || (state_q == DBUS);
        Bo_addr   = addr_q;
        Bo_write  = write_q;
        Bo_size   = size_q;
        Bo_wdata  = wdata_q;
        Fo_ack    = (state_q == RESP) && !owner_q;
        Mo_ack    = (state_q == RESP) && owner_q;
        Mo_busErr = (state_q == RESP) && err_q;
        Fo_rdata  = f_rdata_q;
        Mo_rdata  = m_rdata_q;
        Fo_stall  = Fi_req && !Fo_ack;
        Mo_stall  = Mi_req && !Mo_ack;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Self-checking bench for mem_bus_arbiter. A memory model
//               answers bus cycles; expected bus transfers and responses are
//               queued when requests are driven and compared as they appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int TIMEOUT    = 16;
    localparam int STARVE_MAX = 4;
    localparam int C_STUCK    = 255;

    logic        clk;
    logic        reset_x;
    logic        Fi_req;
    logic [31:0] Fi_addr;
    logic [31:0] Fo_rdata;
    logic        Fo_ack;
    logic        Fo_stall;
    logic        Mi_req;
    logic        Mi_write;
    logic [1:0]  Mi_size;
    logic [31:0] Mi_addr;
    logic [31:0] Mi_wdata;
    logic [31:0] Mo_rdata;
    logic        Mo_ack;
    logic        Mo_stall;
    logic        Mo_busErr;
    logic [31:0] Bo_addr;
    logic        Bo_req;
    logic        Bo_write;
    logic [1:0]  Bo_size;
    logic [31:0] Bo_wdata;
    logic [31:0] Bi_rdata;
    logic        Bi_ack_n;

    int chk_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [1:0]  size;
        logic [31:0] wdata;
        int          wait_n;
        bit          chk_len;
    } bus_item_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    bus_item_t bus_q[$];
    rsp_t      f_q[$];
    rsp_t      m_q[$];

    mem_bus_arbiter #(
        .TIMEOUT    (TIMEOUT),
        .STARVE_MAX (STARVE_MAX)
    ) u_dut (
        .clk       (clk),
        .reset_x   (reset_x),
        .Fi_req    (Fi_req),
        .Fi_addr   (Fi_addr),
        .Fo_rdata  (Fo_rdata),
        .Fo_ack    (Fo_ack),
        .Fo_stall  (Fo_stall),
        .Mi_req    (Mi_req),
        .Mi_write  (Mi_write),
        .Mi_size   (Mi_size),
        .Mi_addr   (Mi_addr),
        .Mi_wdata  (Mi_wdata),
        .Mo_rdata  (Mo_rdata),
        .Mo_ack    (Mo_ack),
        .Mo_stall  (Mo_stall),
        .Mo_busErr (Mo_busErr),
        .Bo_addr   (Bo_addr),
        .Bo_req    (Bo_req),
        .Bo_write  (Bo_write),
        .Bo_size   (Bo_size),
        .Bo_wdata  (Bo_wdata),
        .Bi_rdata  (Bi_rdata),
        .Bi_ack_n  (Bi_ack_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0051_3093;
        return {a[15:0], 16'hC0DE} ^ 32'h1357_0000;
    endfunction

    function automatic int exp_len(input int wait_n);
        return (wait_n >= TIMEOUT) ? TIMEOUT : wait_n + 1;
    endfunction

    task automatic exp_bus(input logic [31:0] a, input logic w, input logic [1:0] s,
                           input logic [31:0] wd, input int wait_n);
        bus_item_t it;
        it.addr = a; it.write = w; it.size = s; it.wdata = wd;
        it.wait_n = wait_n; it.chk_len = 1'b1;
        bus_q.push_back(it);
    endtask

    // Memory model: acks after wait_n wait states; acks freely when idle,
    // which the arbiter must ignore outside a bus transaction.
    initial begin : g_mem
        int mem_cnt;
        int mem_wait;
        Bi_ack_n = 1'b1;
        Bi_rdata = 32'hFFFF_FFFF;
        mem_cnt  = 0;
        mem_wait = 0;
        forever begin
            @(posedge clk);
            #1;
            if (Bo_req) begin
                if (mem_cnt == 0) mem_wait = (bus_q.size() > 0) ? bus_q[0].wait_n : C_STUCK;
                Bi_ack_n = (mem_cnt >= mem_wait) ? 1'b0 : 1'b1;
                Bi_rdata = mem_rd(Bo_addr);
                mem_cnt++;
            end else begin
                mem_cnt  = 0;
                Bi_ack_n = 1'b0;
                Bi_rdata = 32'hFFFF_FFFF;
            end
        end
    end

    // Monitor: bus transfers and responses against the scoreboard queues
    initial begin : g_mon
        bit        prev_req;
        bit        cur_valid;
        int        len;
        bus_item_t cur;
        rsp_t      r;
        prev_req  = 1'b0;
        cur_valid = 1'b0;
        len       = 0;
        forever begin
            @(negedge clk);
            if (Bo_req && !prev_req) begin
                len = 0;
                if (bus_q.size() == 0) begin
                    check("bus_unexpected", 32'(Bo_req), 32'h0);
                    cur_valid = 1'b0;
                end else begin
                    cur = bus_q.pop_front();
                    cur_valid = 1'b1;
                    check("bo_addr",  Bo_addr, cur.addr);
                    check("bo_write", 32'(Bo_write), 32'(cur.write));
                    check("bo_size",  32'(Bo_size), 32'(cur.size));
                    if (cur.write) check("bo_wdata", Bo_wdata, cur.wdata);
                end
            end
            if (Bo_req) len++;
            if (!Bo_req && prev_req && cur_valid && cur.chk_len)
                check("bo_req_len", 32'(len), 32'(exp_len(cur.wait_n)));
            if (Fo_ack || Mo_ack) check("ack_exclusive", 32'(Fo_ack & Mo_ack), 32'h0);
            if (Fo_ack) begin
                if (f_q.size() == 0) check("fo_ack_unexpected", 32'(Fo_ack), 32'h0);
                else begin
                    r = f_q.pop_front();
                    check("fo_rdata", Fo_rdata, r.rdata);
                    check("fo_buserr", 32'(Mo_busErr), 32'(r.err));
                end
            end
            if (Mo_ack) begin
                if (m_q.size() == 0) check("mo_ack_unexpected", 32'(Mo_ack), 32'h0);
                else begin
                    r = m_q.pop_front();
                    check("mo_rdata", Mo_rdata, r.rdata);
                    check("mo_buserr", 32'(Mo_busErr), 32'(r.err));
                end
            end
            if (!Fo_ack && !Mo_ack) check("buserr_no_ack", 32'(Mo_busErr), 32'h0);
            if (Fi_req) check("fo_stall", 32'(Fo_stall), 32'(!Fo_ack));
            if (Mi_req) check("mo_stall", 32'(Mo_stall), 32'(!Mo_ack));
            prev_req = Bo_req;
        end
    end

    task automatic req_fetch(input logic [31:0] a, input logic [31:0] exp_rd,
                             input logic exp_err, input int exp_lat);
        int cyc;
        bit got;
        rsp_t r;
        r.rdata = exp_rd; r.err = exp_err;
        f_q.push_back(r);
        @(posedge clk);
        #1;
        Fi_req  = 1'b1;
        Fi_addr = a;
        cyc = 0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (Fo_ack) got = 1'b1;
            else cyc++;
        end
        check("fo_ack_seen", 32'(got), 32'h1);
        if (exp_lat > 0) check("fo_latency", 32'(cyc), 32'(exp_lat));
    endtask

    task automatic req_data(input logic w, input logic [1:0] s, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] exp_rd,
                            input logic exp_err, input int exp_lat);
        int cyc;
        bit got;
        rsp_t r;
        r.rdata = exp_rd; r.err = exp_err;
        m_q.push_back(r);
        @(posedge clk);
        #1;
        Mi_req   = 1'b1;
        Mi_write = w;
        Mi_size  = s;
        Mi_addr  = a;
        Mi_wdata = wd;
        cyc = 0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (Mo_ack) got = 1'b1;
            else cyc++;
        end
        check("mo_ack_seen", 32'(got), 32'h1);
        if (exp_lat > 0) check("mo_latency", 32'(cyc), 32'(exp_lat));
    endtask

    task automatic drop_fetch();
        @(posedge clk);
        #1;
        Fi_req = 1'b0;
    endtask

    task automatic drop_data();
        @(posedge clk);
        #1;
        Mi_req = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_bo_req"},   32'(Bo_req), 32'h0);
        check({tag, "_bo_write"}, 32'(Bo_write), 32'h0);
        check({tag, "_bo_addr"},  Bo_addr, 32'h0);
        check({tag, "_bo_wdata"}, Bo_wdata, 32'h0);
        check({tag, "_bo_size"},  32'(Bo_size), 32'h2);
        check({tag, "_fo_ack"},   32'(Fo_ack), 32'h0);
        check({tag, "_mo_ack"},   32'(Mo_ack), 32'h0);
        check({tag, "_buserr"},   32'(Mo_busErr), 32'h0);
        check({tag, "_fo_rdata"}, Fo_rdata, 32'h0);
        check({tag, "_mo_rdata"}, Mo_rdata, 32'h0);
    endtask

    // Store to daddr and fetch from faddr raised together: data wins
    task automatic simul_test(input logic [31:0] faddr, input logic [31:0] daddr);
        exp_bus(daddr, 1'b1, 2'b00, 32'hDEAD_BEEF, 0);
        exp_bus(faddr, 1'b0, 2'b10, 32'h0, 0);
        fork
            begin
                req_data(1'b1, 2'b00, daddr, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
                drop_data();
            end
            begin
                req_fetch(faddr, mem_rd(faddr), 1'b0, 5);
                drop_fetch();
            end
        join
    endtask

    initial begin : g_timeout
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation did not finish");
    end

    initial begin : g_main
        bus_item_t it;
        reset_x  = 1'b0;
        Fi_req   = 1'b0;
        Fi_addr  = 32'h0;
        Mi_req   = 1'b0;
        Mi_write = 1'b0;
        Mi_size  = 2'b10;
        Mi_addr  = 32'h0;
        Mi_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("por");
        @(posedge clk);
        #1;
        reset_x = 1'b1;

        // Reset in the middle of a data transaction that memory never acks
        it.addr = 32'h40; it.write = 1'b1; it.size = 2'b01; it.wdata = 32'h1234_5678;
        it.wait_n = C_STUCK; it.chk_len = 1'b0;
        bus_q.push_back(it);
        @(posedge clk);
        #1;
        Mi_req = 1'b1; Mi_write = 1'b1; Mi_size = 2'b01;
        Mi_addr = 32'h40; Mi_wdata = 32'h1234_5678;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        reset_x = 1'b0;
        Mi_req  = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset_x = 1'b1;
        @(negedge clk);
        check_reset_values("midrst");

        // Single fetch with memory acking in the first bus cycle
        exp_bus(32'h100, 1'b0, 2'b10, 32'h0, 0);
        req_fetch(32'h100, 32'h0051_3093, 1'b0, 2);
        drop_fetch();

        // Simultaneous requests
        simul_test(32'h300, 32'h2000);

        // Starvation: fetch held while data re-requests after every ack
        for (int k = 0; k < 4; k++)
            exp_bus(32'h1000 + 32'(4 * k), 1'(k % 2), 2'b10, 32'hA000_0000 + 32'(k), 0);
        exp_bus(32'h400, 1'b0, 2'b10, 32'h0, 0);
        exp_bus(32'h1010, 1'b0, 2'b10, 32'hA000_0004, 0);
        fork
            begin
                req_fetch(32'h400, mem_rd(32'h400), 1'b0, 14);
                drop_fetch();
            end
            begin
                for (int k = 0; k < 5; k++) begin
                    logic [31:0] a;
                    logic        w;
                    a = 32'h1000 + 32'(4 * k);
                    w = 1'(k % 2);
                    req_data(w, 2'b10, a, 32'hA000_0000 + 32'(k),
                             w ? 32'h0 : mem_rd(a), 1'b0, (k == 4) ? 5 : 2);
                end
                drop_data();
            end
        join

        // Starve count must be clear again: data still wins a tie
        simul_test(32'h500, 32'h2004);

        // Three wait states on a load
        exp_bus(32'h3000, 1'b0, 2'b10, 32'h0, 3);
        req_data(1'b0, 2'b10, 32'h3000, 32'h0, mem_rd(32'h3000), 1'b0, 5);
        drop_data();

        // Watchdog abort on a load
        exp_bus(32'h3004, 1'b0, 2'b10, 32'h0, C_STUCK);
        req_data(1'b0, 2'b10, 32'h3004, 32'h0, 32'h0, 1'b1, TIMEOUT + 1);
        drop_data();

        // Fetch with one wait state after the abort
        exp_bus(32'h104, 1'b0, 2'b10, 32'h0, 1);
        req_fetch(32'h104, mem_rd(32'h104), 1'b0, 3);
        drop_fetch();

        repeat (3) @(posedge clk);
        check("bus_q_drained", 32'(bus_q.size()), 32'h0);
        check("f_q_drained",   32'(f_q.size()),   32'h0);
        check("m_q_drained",   32'(m_q.size()),   32'h0);
        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares one external memory bus between the pipeline's instruction-fetch port (F stage) and data port (M stage). It serialises their requests and runs the active-low acknowledge handshake with memory. It returns registered read data and one-cycle acknowledge pulses to each requester, and drives stall requests into the hazard unit. A watchdog turns a missing memory acknowledge into a bus-error pulse for the exception logic.

## Interface
Parameters:
- TIMEOUT, 16: cycles allowed in a bus transaction before abort. Legal range 2..255.
- STARVE_MAX, 4: consecutive data grants allowed while fetch is waiting; the next grant then goes to fetch. Legal range 1..15.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset_x  in  1  synchronous, active-low reset.
- Fi_req  in  1  fetch request; held high until Fo_ack.
- Fi_addr  in  32  fetch address.
- Fo_rdata  out  32  fetched word, valid while Fo_ack is high.
- Fo_ack  out  1  one-cycle fetch completion pulse.
- Fo_stall  out  1  Fi_req & ~Fo_ack (combinational).
- Mi_req  in  1  data request; held high until Mo_ack.
- Mi_write  in  1  1 = store.
- Mi_size  in  2  access size, passed through unchanged.
- Mi_addr  in  32  data address.
- Mi_wdata  in  32  store data.
- Mo_rdata  out  32  load data, valid while Mo_ack is high.
- Mo_ack  out  1  one-cycle data completion pulse.
- Mo_stall  out  1  Mi_req & ~Mo_ack (combinational).
- Mo_busErr  out  1  one-cycle pulse on watchdog abort, coincident with the requester's ack.
- Bo_addr  out  32  bus address.
- Bo_req  out  1  bus request.
- Bo_write  out  1  bus write enable.
- Bo_size  out  2  bus access size.
- Bo_wdata  out  32  bus write data.
- Bi_rdata  in  32  bus read data.
- Bi_ack_n  in  1  active-low bus acknowledge.

## Operation
- States: IDLE, FBUS, DBUS, RESP.
- IDLE, grant decision:
  - If Mi_req and (starve count < STARVE_MAX or ~Fi_req): go to DBUS.
  - Else if Fi_req: go to FBUS.
  - Otherwise stay in IDLE.
- On grant, latch address, write, size and wdata into bus registers. Fetch always latches write=0 and size=2'b10.
- Starve counter (4 bits):
  - Increments on each data grant made while Fi_req is high.
  - Clears on each fetch grant, and when Fi_req is low at a data grant.
  - Saturates at STARVE_MAX.
- FBUS/DBUS: Bo_req=1 and bus outputs driven from the latches. The watchdog counter starts at 0 on entry and increments each cycle.
- Bi_ack_n sampled 0 in FBUS/DBUS: capture Bi_rdata into the owner's rdata register and go to RESP. Captured data is 32'h0 for stores.
- Watchdog reaches TIMEOUT-1 with Bi_ack_n still 1: rdata register gets 32'h0, the busErr flag is set, and the state goes to RESP.
- RESP (one cycle):
  - Bo_req=0.
  - The owner's ack is 1.
  - Mo_busErr = flag.
  - No grant is made in this cycle, so a requester that drops its request on seeing ack is never re-served.
  - Next state is IDLE.
- Bus registers hold their values outside transactions; only Bo_req qualifies them.
- Mi_req/Fi_req deasserted mid-transaction is illegal; the transaction completes regardless.

## Timing
- Reset values (reset_x low at an edge, from any state, including mid-transaction):
  - State IDLE.
  - Bo_req, Bo_write, Fo_ack, Mo_ack, Mo_busErr = 0.
  - Bo_addr, Bo_wdata, Fo_rdata, Mo_rdata = 0.
  - Bo_size = 2'b10.
  - Starve and watchdog counters = 0.
- Minimum latency, request high in cycle 0 (IDLE):
  - Bo_req=1 in cycle 1.
  - With Bi_ack_n=0 in cycle 1, ack and rdata are valid in cycle 2.
  - IDLE again in cycle 3, so back-to-back throughput is one access per 3 cycles.
- Each extra cycle of Bi_ack_n=1 adds one cycle of latency.
- Timeout: Bo_req stays high for exactly TIMEOUT cycles, then RESP follows.
- Fo_ack and Mo_ack are never high in the same cycle.
- Bi_ack_n is ignored outside FBUS/DBUS.

## Test plan
- Reset: hold reset_x=0 for 2 cycles during a DBUS transaction -> next cycle Bo_req=0 and all outputs at reset values; a subsequent Fi_req is served normally.
- Single fetch: Fi_req=1, Fi_addr=32'h0000_0100, memory acks in the first bus cycle with 32'h0051_3093 -> Bo_addr=32'h100, Bo_write=0, Bo_size=2'b10 in cycle 1; Fo_ack=1, Fo_rdata=32'h0051_3093 in cycle 2; Fo_stall=1 in cycles 0-1.
- Simultaneous requests: Fi_req=1 and Mi_req=1 (store of 32'hDEAD_BEEF to 32'h2000, size 2'b00) in the same cycle -> data granted first with Bo_write=1 and Bo_size=2'b00; Mo_ack pulses; fetch is granted 2 cycles after Mo_ack.
- Starvation: Fi_req held high while Mi_req is re-raised immediately after every ack, STARVE_MAX=4 -> exactly 4 data transactions, then one fetch transaction, then the starve count is 0.
- Wait states: memory holds Bi_ack_n=1 for 3 bus cycles on a load -> Bo_req high for 4 cycles, Mo_ack 5 cycles after the request, Mo_busErr=0.
- Timeout: Bi_ack_n stuck at 1, TIMEOUT=16, load request -> Bo_req high for 16 cycles, then Mo_ack=1, Mo_busErr=1, Mo_rdata=0 for one cycle; IDLE next.
